pmp_check_ctrl: RTL and testbench

//  Sequences PMP permission checks for one outstanding access at a time.

---
 rtl/pmp_check_ctrl_pkg.sv | 44 ++++
 rtl/pmp_check_ctrl_addr_check.sv | 28 ++
 rtl/pmp_check_ctrl.sv | 154 +++++++++++++++
 tb/tb_pmp_check_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pmp_check_ctrl_pkg.sv
// PMP field/enum types shared by the check controller and its address comparators.
// Also holds the fault decision so the controller and any future users agree on it.
package pmp_check_ctrl_pkg;

    typedef enum logic [1:0] {
        PMP_OFF   = 2'd0,
        PMP_TOR   = 2'd1,
        PMP_NA4   = 2'd2,
        PMP_NAPOT = 2'd3
    } pmp_a_e;

    typedef enum logic [1:0] {
        ACC_R    = 2'd0,
        ACC_W    = 2'd1,
        ACC_X    = 2'd2,
        ACC_RSVD = 2'd3
    } pmp_acc_e;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        pmp_a_e     a;
        logic       x;
        logic       w;
        logic       r;
    } pmp_cfg_t;

    // Reserved access code 11 is checked as a read.
    function automatic logic pmp_fault(input pmp_cfg_t cfg, input logic [1:0] acc,
                                       input logic mmode, input logic hit);
        logic perm;
        case (acc)
            2'b01:   perm = cfg.w;
            2'b10:   perm = cfg.x;
            default: perm = cfg.r;
        endcase
        if (!hit)
            return !mmode;
        if (mmode && !cfg.l)
            return 1'b0;
        return !perm;
    endfunction

endpackage

// File: rtl/pmp_check_ctrl_addr_check.sv
// Single-entry PMP address comparator (OFF/TOR/NA4/NAPOT); purely combinational.
// Zero latency, no flow control.
module pmp_addr_check
    import pmp_check_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  pmp_a_e                cfg_a,
    input  logic [ADDR_WIDTH-1:0] pmp_addr,
    input  logic [ADDR_WIDTH-1:0] pmp_addr_last,
    output logic                  match
);

    logic [ADDR_WIDTH-1:0] napot_mask;

    always_comb begin
        // Trailing ones of pmpaddr plus the next bit encode the region size.
        napot_mask = ~(pmp_addr ^ (pmp_addr + ADDR_WIDTH'(1)));
        case (cfg_a)
            PMP_TOR:   match = (addr >= pmp_addr_last) && (addr < pmp_addr);
            PMP_NA4:   match = (addr == pmp_addr);
            PMP_NAPOT: match = ((addr & napot_mask) == (pmp_addr & napot_mask));
            default:   match = 1'b0;
        endcase
    end

endmodule

// File: rtl/pmp_check_ctrl.sv
// PMP check sequencer: scans LANES entries per cycle, lowest hit wins; response after groups+1 edges.
// One request outstanding; req_ready only in IDLE, response held until resp_ready.
module pmp_check_ctrl
    import pmp_check_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int PMP_NUM    = 16,
    parameter int LANES      = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [ADDR_WIDTH-1:0]               req_addr,
    input  logic [1:0]                          req_acc,
    input  logic                                req_mmode,
    input  logic [PMP_NUM-1:0][7:0]             pmp_cfg,
    input  logic [PMP_NUM-1:0][ADDR_WIDTH-1:0]  pmp_addr,
    input  logic                                cfg_update,
    output logic                                resp_valid,
    input  logic                                resp_ready,
    output logic                                resp_fault,
    output logic [$clog2(PMP_NUM)-1:0]          resp_hit_idx,
    output logic                                resp_hit
);

    localparam int IDX_W  = $clog2(PMP_NUM);
    localparam int NGRP   = PMP_NUM / LANES;
    localparam int GRP_W  = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NGRP - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [GRP_W-1:0]      grp_q, grp_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            acc_q, acc_d;
    logic                  mmode_q, mmode_d;
    logic                  fault_q, fault_d;
    logic                  hit_q, hit_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic [IDX_W-1:0]      lane_idx  [LANES];
    logic [ADDR_WIDTH-1:0] lane_last [LANES];
    pmp_cfg_t              lane_cfg  [LANES];
    logic [LANES-1:0]      lane_match;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_idx[g]  = IDX_W'(32'(grp_q) * LANES + g);
        assign lane_cfg[g]  = pmp_cfg_t'(pmp_cfg[lane_idx[g]]);
        assign lane_last[g] = (lane_idx[g] == '0) ? '0 : pmp_addr[lane_idx[g] - IDX_W'(1)];

        pmp_addr_check #(
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_addr_check (
            .addr          (addr_q),
            .cfg_a         (lane_cfg[g].a),
            .pmp_addr      (pmp_addr[lane_idx[g]]),
            .pmp_addr_last (lane_last[g]),
            .match         (lane_match[g])
        );
    end

    logic              hit_any;
    logic [LANE_W-1:0] hit_lane;

    always_comb begin
        hit_any  = 1'b0;
        hit_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_match[i]) begin
                hit_any  = 1'b1;
                hit_lane = LANE_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        mmode_d = mmode_q;
        fault_d = fault_q;
        hit_d   = hit_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    acc_d   = req_acc;
                    mmode_d = req_mmode;
                    grp_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // A config write invalidates partial results, even a hit found this cycle.
                if (cfg_update) begin
                    grp_d = '0;
                end else if (hit_any) begin
                    hit_d   = 1'b1;
                    idx_d   = lane_idx[hit_lane];
                    fault_d = pmp_fault(lane_cfg[hit_lane], acc_q, mmode_q, 1'b1);
                    state_d = ST_RESP;
                end else if (grp_q == LAST_GRP) begin
                    hit_d   = 1'b0;
                    idx_d   = '0;
                    fault_d = !mmode_q;
                    state_d = ST_RESP;
                end else begin
                    grp_d = grp_q + GRP_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grp_q   <= '0;
            addr_q  <= '0;
            acc_q   <= '0;
            mmode_q <= 1'b0;
            fault_q <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            mmode_q <= mmode_d;
            fault_q <= fault_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign resp_valid   = (state_q == ST_RESP);
    assign resp_fault   = fault_q;
    assign resp_hit     = hit_q;
    assign resp_hit_idx = idx_q;

endmodule

// File: tb/tb_pmp_check_ctrl.sv
// Directed bench for pmp_check_ctrl: hand-computed hit/fault/latency per vector.
module tb_pmp_check_ctrl;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [31:0]       req_addr = '0;
    logic [1:0]        req_acc = '0;
    logic              req_mmode = 1'b0;
    logic [15:0][7:0]  pmp_cfg = '0;
    logic [15:0][31:0] pmp_addr = '0;
    logic              cfg_update = 1'b0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic              resp_fault;
    logic [3:0]        resp_hit_idx;
    logic              resp_hit;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;

    always #5 clk = ~clk;

    pmp_check_ctrl #(.ADDR_WIDTH(32), .PMP_NUM(16), .LANES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_acc      (req_acc),
        .req_mmode    (req_mmode),
        .pmp_cfg      (pmp_cfg),
        .pmp_addr     (pmp_addr),
        .cfg_update   (cfg_update),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_fault   (resp_fault),
        .resp_hit_idx (resp_hit_idx),
        .resp_hit     (resp_hit)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic start_req(input logic [31:0] a, input logic [1:0] acc, input logic mm);
        req_addr  = a;
        req_acc   = acc;
        req_mmode = mm;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // n0 = edges already seen counting the accept edge as 1.
    task automatic wait_resp(input string tag, input int n0, output int n);
        n = n0;
        while (!resp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, 32'(resp_valid), 1);
    endtask

    task automatic check_resp(input string tag, input int exp_lat, input logic exp_hit,
                              input logic [3:0] exp_idx, input logic exp_fault);
        chk({tag, "_lat"},   lat, exp_lat);
        chk({tag, "_hit"},   32'(resp_hit), 32'(exp_hit));
        chk({tag, "_idx"},   32'(resp_hit_idx), 32'(exp_idx));
        chk({tag, "_fault"}, 32'(resp_fault), 32'(exp_fault));
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [1:0] acc,
                       input logic mm, input int exp_lat, input logic exp_hit,
                       input logic [3:0] exp_idx, input logic exp_fault);
        start_req(a, acc, mm);
        wait_resp(tag, 1, lat);
        check_resp(tag, exp_lat, exp_hit, exp_idx, exp_fault);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_req_ready",  32'(req_ready), 1);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_fault",      32'(resp_fault), 0);
        chk("rst_hit",        32'(resp_hit), 0);
        chk("rst_idx",        32'(resp_hit_idx), 0);

        // Entry 0 NAPOT 0x3FF (units 0..0x7FF), R only.
        pmp_cfg[0]  = 8'h19;
        pmp_addr[0] = 32'h0000_03FF;
        run("t1_u_rd",  32'h100, 2'b00, 1'b0, 2, 1'b1, 4'd0, 1'b0);
        run("t2_u_wr",  32'h100, 2'b01, 1'b0, 2, 1'b1, 4'd0, 1'b1);
        run("t2_m_wr",  32'h100, 2'b01, 1'b1, 2, 1'b1, 4'd0, 1'b0);
        run("t2_u_rsv", 32'h100, 2'b11, 1'b0, 2, 1'b1, 4'd0, 1'b0);
        pmp_cfg[0] = 8'h99;
        run("t2_m_wr_l", 32'h100, 2'b01, 1'b1, 2, 1'b1, 4'd0, 1'b1);
        run("t2_m_rd_l", 32'h100, 2'b00, 1'b1, 2, 1'b1, 4'd0, 1'b0);

        // Entry 13 TOR [0x2000, 0x3000) RWX, everything else OFF.
        pmp_cfg = '0;
        pmp_addr = '0;
        pmp_addr[12] = 32'h2000;
        pmp_addr[13] = 32'h3000;
        pmp_cfg[13]  = 8'h0F;
        run("t3_top",   32'h2FFF, 2'b00, 1'b0, 5, 1'b1, 4'd13, 1'b0);
        run("t3_bot",   32'h2000, 2'b10, 1'b0, 5, 1'b1, 4'd13, 1'b0);
        run("t3_end_u", 32'h3000, 2'b00, 1'b0, 5, 1'b0, 4'd0,  1'b1);
        run("t3_end_m", 32'h3000, 2'b00, 1'b1, 5, 1'b0, 4'd0,  1'b0);

        // Entry 5 NA4 0x40 R only, entry 6 NAPOT 0x40..0x4F RWX.
        pmp_cfg = '0;
        pmp_addr = '0;
        pmp_addr[5] = 32'h40;
        pmp_cfg[5]  = 8'h11;
        pmp_addr[6] = 32'h47;
        pmp_cfg[6]  = 8'h1F;
        run("t4_prio", 32'h40, 2'b01, 1'b0, 3, 1'b1, 4'd5, 1'b1);
        run("t4_e6",   32'h41, 2'b01, 1'b0, 3, 1'b1, 4'd6, 1'b0);

        // Entries 9 (RWX) and 10 (R only) both NA4 0x500.
        pmp_cfg = '0;
        pmp_addr = '0;
        pmp_addr[9]  = 32'h500;
        pmp_cfg[9]   = 8'h17;
        pmp_addr[10] = 32'h500;
        pmp_cfg[10]  = 8'h11;
        run("t5_base", 32'h500, 2'b01, 1'b0, 4, 1'b1, 4'd9, 1'b0);
        start_req(32'h500, 2'b01, 1'b0);
        @(posedge clk); #1;
        cfg_update = 1'b1;
        pmp_cfg[9] = 8'h00;
        @(posedge clk); #1;
        cfg_update = 1'b0;
        wait_resp("t5_upd", 3, lat);
        check_resp("t5_upd", 6, 1'b1, 4'd10, 1'b1);
        @(posedge clk); #1;

        // Held response, with a config write during RESP that must not disturb it.
        resp_ready = 1'b0;
        start_req(32'h500, 2'b00, 1'b0);
        wait_resp("t6_hold", 1, lat);
        check_resp("t6_hold", 4, 1'b1, 4'd10, 1'b0);
        cfg_update = 1'b1;
        pmp_cfg[10] = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            cfg_update = 1'b0;
            chk("t6_hold_valid", 32'(resp_valid), 1);
            chk("t6_hold_idx",   32'(resp_hit_idx), 10);
            chk("t6_hold_fault", 32'(resp_fault), 0);
            chk("t6_hold_rdy",   32'(req_ready), 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("t6_rel_valid", 32'(resp_valid), 0);
        chk("t6_rel_rdy",   32'(req_ready), 1);

        // Reset mid-SCAN: request is dropped and no response follows.
        pmp_cfg[10] = 8'h11;
        start_req(32'h500, 2'b00, 1'b0);
        chk("t6_scan_rdy", 32'(req_ready), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_rst_rdy",   32'(req_ready), 1);
        chk("t6_rst_valid", 32'(resp_valid), 0);
        chk("t6_rst_hit",   32'(resp_hit), 0);
        chk("t6_rst_idx",   32'(resp_hit_idx), 0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("t6_rst_quiet", 32'(resp_valid), 0);
        end
        run("t6_after", 32'h500, 2'b00, 1'b0, 4, 1'b1, 4'd10, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
